// File: rtl/seg7_pkg.sv
// Shared definitions for 7-segment display blocks: digit count, segment
// constants and the BCD-to-segment table (active-low, {g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry [n] is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] msec;
  } bcd_time_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes
// show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i < 4'd10) begin
      seg_o = SEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit common-anode display driver with per-frame
// snapshot of the stopwatch BCD value, slot blanking and blinking decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [7:0] msec,
  input  logic       run,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      fc_q, fc_d;
  bcd_time_t       s1_q, s2_q, snap_q, snap_d;
  logic            run_s1_q, run_s2_q;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0]      an_q, an_d;

  logic            slot_end, frame_wrap;
  logic [3:0]      digit;
  logic [6:0]      dec_seg;

  assign slot_end   = (div_cnt_q == CntW'(SCAN_DIV - 1));
  assign frame_wrap = slot_end && (idx_q == 3'(NUM_DIGITS - 1));

  always_comb begin
    div_cnt_d = slot_end ? '0 : div_cnt_q + CntW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? 3'd0 : idx_q + 3'd1;
    end
    fc_d   = frame_wrap ? fc_q + 7'd1 : fc_q;
    // Only accept a value seen identically on two consecutive samples, so a
    // count caught mid-increment never reaches the display.
    snap_d = (frame_wrap && (s1_q == s2_q)) ? s2_q : snap_q;
  end

  always_comb begin
    digit = 4'd0;
    unique case (idx_q)
      3'd0:    digit = snap_q.msec[3:0];
      3'd1:    digit = snap_q.msec[7:4];
      3'd2:    digit = snap_q.sec[3:0];
      3'd3:    digit = snap_q.sec[7:4];
      3'd4:    digit = snap_q.min[3:0];
      3'd5:    digit = snap_q.min[7:4];
      default: digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = 6'h3F;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (div_cnt_q >= CntW'(BLANK_CYC)) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = dec_seg;
      if ((LZ_BLANK == 1) && (idx_q == 3'd5) && (digit == 4'd0)) begin
        seg_d = SEG_BLANK;
      end
      // Steady while running, blinks with frame counter bit 6 when stopped.
      if (((idx_q == 3'd2) || (idx_q == 3'd4)) && (run_s2_q || !fc_q[6])) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_cnt_q <= '0;
      idx_q     <= 3'd0;
      fc_q      <= 7'd0;
      s1_q      <= '0;
      s2_q      <= '0;
      snap_q    <= '0;
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= 6'h3F;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      fc_q      <= fc_d;
      s1_q      <= '{min: min, sec: sec, msec: msec};
      s2_q      <= s1_q;
      snap_q    <= snap_d;
      run_s1_q  <= run;
      run_s2_q  <= run_s1_q;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2; a second
// instance with leading-zero blanking disabled shares all inputs.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] min, sec, msec;
  logic       run;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic [5:0] an, an2;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
    .clk(clk), .n_reset(n_reset), .min(min), .sec(sec), .msec(msec), .run(run),
    .seg(seg), .dp(dp), .an(an)
  );

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_BLANK(0)) dut_nlz (
    .clk(clk), .n_reset(n_reset), .min(min), .sec(sec), .msec(msec), .run(run),
    .seg(seg2), .dp(dp2), .an(an2)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; outputs sampled after edge k show counter state k-1.
  int k = 0;
  always @(posedge clk) begin
    if (!n_reset) k <= 0;
    else          k <= k + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int         pos;
    logic [6:0] seg;
    logic [6:0] seg2;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // snap is {min, sec, msec}; digit s is nibble s counting from the LSB.
  task automatic push_slot(input int f, input int s, input logic [23:0] snap, input logic run_on);
    exp_t       e;
    logic [3:0] d;
    d      = snap[4*s +: 4];
    e.pos  = f * 6 + s;
    e.seg2 = seg_of(d);
    e.seg  = (s == 5 && d == 4'd0) ? 7'h7F : e.seg2;
    e.dp   = ((s == 2 || s == 4) && (run_on || (f % 128) < 64)) ? 1'b0 : 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int f, input logic [23:0] snap, input logic run_on);
    for (int s = 0; s < 6; s++) push_slot(f, s, snap, run_on);
  endtask

  task automatic wait_t(input int tt);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (guard > 50000) begin
        $display("FAIL wait_t: got timeout expected step %0d", tt);
        $fatal(1);
      end
    end while (!(n_reset && (k - 1) == tt));
  endtask

  // Monitor: blanking/anode rotation every cycle, scoreboard mid-slot.
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset && k >= 1) begin
        int         t, dv, sl, pos;
        logic [5:0] exp_an;
        t      = k - 1;
        dv     = t % 8;
        sl     = (t / 8) % 6;
        pos    = (t / 48) * 6 + sl;
        exp_an = ~(6'b000001 << sl);
        if (dv < 2) begin
          check_eq("blank_an", an, 6'h3F);
          check_eq("blank_seg", seg, 7'h7F);
          check_eq("blank_dp", dp, 1'b1);
        end else begin
          check_eq("an_rot", an, exp_an);
        end
        if (dv == 4) begin
          while (sb.size() > 0 && sb[0].pos < pos) begin
            check_eq("missed_slot", sb[0].pos, pos);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].pos == pos) begin
            exp_t e;
            e = sb.pop_front();
            check_eq($sformatf("seg_f%0d_s%0d", pos / 6, sl), seg, e.seg);
            check_eq($sformatf("seg_nlz_f%0d_s%0d", pos / 6, sl), seg2, e.seg2);
            check_eq($sformatf("dp_f%0d_s%0d", pos / 6, sl), dp, e.dp);
            check_eq($sformatf("dp_nlz_f%0d_s%0d", pos / 6, sl), dp2, e.dp);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    min = 8'h12; sec = 8'h34; msec = 8'h56; run = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_an", an, 6'h3F);
    check_eq("reset_seg", seg, 7'h7F);
    check_eq("reset_dp", dp, 1'b1);
    n_reset = 1'b1;

    // Frame 0 shows the reset snapshot, frame 1 the captured inputs.
    push_slot(0, 0, 24'h0, 1'b1);
    push_slot(0, 2, 24'h0, 1'b1);
    push_slot(0, 5, 24'h0, 1'b1);
    push_frame(1, 24'h123456, 1'b1);

    // Leading zero on min tens, invalid BCD in msec tenths.
    wait_t(48 + 20);
    min  = 8'h05;
    msec = 8'hA9;
    push_frame(2, 24'h0534A9, 1'b1);

    // Tearing: sec toggles across the frame-2 wrap, then settles.
    push_frame(3, 24'h0534A9, 1'b1);
    push_frame(4, 24'h0559A9, 1'b1);
    wait_t(96 + 40);
    for (int i = 0; i < 12; i++) begin
      sec = (i % 2 == 1) ? 8'h77 : 8'h88;
      @(negedge clk);
    end
    sec = 8'h59;

    // Stopped: decimal points blink with frame counter bit 6.
    wait_t(5 * 48);
    run = 1'b0;
    push_slot(10, 2, 24'h0559A9, 1'b0);
    push_slot(10, 4, 24'h0559A9, 1'b0);
    push_slot(63, 2, 24'h0559A9, 1'b0);
    push_slot(63, 4, 24'h0559A9, 1'b0);
    push_slot(64, 2, 24'h0559A9, 1'b0);
    push_slot(64, 4, 24'h0559A9, 1'b0);
    push_slot(65, 0, 24'h0559A9, 1'b0);

    // Asynchronous reset in the middle of slot 1.
    wait_t(65 * 48 + 13);
    n_reset = 1'b0;
    #1;
    check_eq("midreset_an", an, 6'h3F);
    check_eq("midreset_seg", seg, 7'h7F);
    check_eq("midreset_dp", dp, 1'b1);
    check_eq("midreset_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    push_slot(0, 0, 24'h0, 1'b0);
    push_slot(0, 5, 24'h0, 1'b0);
    push_frame(1, 24'h0559A9, 1'b0);

    wait_t(2 * 48 + 10);
    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
